// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I ALU/branch sequencer: opcodes, ALU op codes,
// FSM state encoding and the instruction class seen by the FSM.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_MEM = 3'd2;
  localparam logic [2:0] ST_DECODE   = 3'd3;
  localparam logic [2:0] ST_EXEC     = 3'd4;
  localparam logic [2:0] ST_WB       = 3'd5;
  localparam logic [2:0] ST_HALT     = 3'd6;
  localparam logic [2:0] ST_ERR      = 3'd7;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_ALUI   = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_SYS    = 2'd3
  } instr_class_t;

  // funct3 -> ALU op; alt selects SUB/SRA (instr[30])
  function automatic logic [3:0] alu_op_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_seq_decode.sv
// Combinational RV32I decoder for the ALU/branch subset: register selects,
// sign-extended immediate, ALU op, instruction class and illegal flag.
module riscv_seq_decode
  import riscv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [3:0]       alu_op,
  output logic             alu_src_imm,
  output logic [WIDTH-1:0] imm,
  output instr_class_t     cls,
  output logic             is_bne,
  output logic             illegal
);

  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [WIDTH-1:0] imm_i;
  logic [WIDTH-1:0] imm_b;

  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign is_bne = instr[12];
  assign imm_i  = {{(WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_b  = {{(WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    imm         = '0;
    cls         = CLS_ALU;
    illegal     = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        cls     = CLS_ALU;
        alu_op  = alu_op_from_f3(f3, f7[5]);
        illegal = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OPIMM: begin
        cls         = CLS_ALUI;
        alu_src_imm = 1'b1;
        imm         = imm_i;
        // only shifts carry a funct7 field; ADDI etc. use those bits as immediate
        alu_op      = alu_op_from_f3(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)
          illegal = (f7 != 7'h00);
        else if (f3 == 3'b101)
          illegal = !((f7 == 7'h00) || (f7 == 7'h20));
      end
      OPC_BRANCH: begin
        cls     = CLS_BRANCH;
        alu_op  = ALU_SUB;
        imm     = imm_b;
        illegal = (f3[2:1] != 2'b00);
      end
      OPC_SYSTEM: begin
        cls     = CLS_SYS;
        illegal = !((instr == 32'h0000_0073) || (instr == 32'h0010_0073));
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer: owns the PC, instruction register
// and memory timeout; pulse outputs are decoded from state so reset kills them at once.
module riscv_seq_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              alu_zero,
  output logic [4:0]        rf_rs1,
  output logic [4:0]        rf_rs2,
  output logic [4:0]        rf_rd,
  output logic              rf_we,
  output logic [3:0]        alu_op,
  output logic              alu_src_imm,
  output logic [WIDTH-1:0]  imm,
  output logic              retired,
  output logic              halt,
  output logic              err
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MEM_TIMEOUT - 1);

  logic [2:0]        state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [31:0]       ir_reg;
  logic [TW-1:0]     ctr_reg;
  logic              taken_reg;

  instr_class_t      cls;
  logic              is_bne;
  logic              illegal;
  logic [ADDR_W-1:0] target;
  logic              bad_target;

  riscv_seq_decode #(.WIDTH(WIDTH)) u_decode (
    .instr       (ir_reg),
    .rs1         (rf_rs1),
    .rs2         (rf_rs2),
    .rd          (rf_rd),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .imm         (imm),
    .cls         (cls),
    .is_bne      (is_bne),
    .illegal     (illegal)
  );

  assign target     = pc_reg + ADDR_W'(imm);
  assign bad_target = taken_reg && (target[1:0] != 2'b00);

  assign imem_addr = pc_reg;
  assign imem_req  = (state_reg == ST_FETCH) && !stall;
  assign rf_we     = (state_reg == ST_WB) && !stall && (rf_rd != 5'd0) &&
                     ((cls == CLS_ALU) || (cls == CLS_ALUI));
  assign retired   = (state_reg == ST_WB) && !stall && !bad_target;
  assign halt      = (state_reg == ST_HALT);
  assign err       = (state_reg == ST_ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      ctr_reg   <= '0;
      taken_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: state_reg <= ST_FETCH;
        ST_FETCH: if (!stall) begin
          ctr_reg   <= '0;
          state_reg <= ST_WAIT_MEM;
        end
        // stall is deliberately ignored here so a returning word is never dropped
        ST_WAIT_MEM: begin
          if (imem_valid) begin
            ir_reg    <= imem_rdata;
            state_reg <= ST_DECODE;
          end else if (ctr_reg == TIMEOUT_LAST) begin
            state_reg <= ST_ERR;
          end else begin
            ctr_reg <= ctr_reg + TW'(1);
          end
        end
        ST_DECODE: if (!stall) state_reg <= illegal ? ST_ERR : ST_EXEC;
        ST_EXEC: if (!stall) begin
          taken_reg <= (cls == CLS_BRANCH) && (is_bne ? !alu_zero : alu_zero);
          state_reg <= ST_WB;
        end
        ST_WB: if (!stall) begin
          if (cls == CLS_SYS) begin
            state_reg <= ST_HALT;
          end else if (bad_target) begin
            state_reg <= ST_ERR;
          end else begin
            pc_reg    <= taken_reg ? target : pc_reg + ADDR_W'(4);
            state_reg <= ST_FETCH;
          end
        end
        default: state_reg <= state_reg;
      endcase
    end
  end

endmodule
